// File: rtl/alu_serial_pkg.sv
// rtl/alu_serial_pkg.sv - shared FSM states and opcodes for the bit-serial add/sub path
package alu_serial_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder, the only arithmetic element of the serial ALU
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub_ctrl.sv
// rtl/serial_addsub_ctrl.sv - bit-serial add/subtract sequencer, one bit per cycle LSB first
module serial_addsub_ctrl
  import alu_serial_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [WIDTH-1:0] result_next;
  logic             carry;
  logic             sum_bit;
  logic             cout;
  logic             load;
  logic             step;
  logic             last_bit;

  full_adder u_full_adder (
    .a    (shift_a[0]),
    .b    (shift_b[0]),
    .cin  (carry),
    .sum  (sum_bit),
    .cout (cout)
  );

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt == LAST_BIT) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = S_RUN;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign last_bit    = step && (cnt == LAST_BIT);
  assign result_next = {sum_bit, result[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Subtraction is a + ~b + 1: the inverted operand and the carry-in of one are set up at load.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      carry   <= 1'b0;
      shift_a <= '0;
      shift_b <= '0;
      result  <= '0;
      flag_n  <= 1'b0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      flag_v  <= 1'b0;
    end else if (load) begin
      cnt     <= '0;
      carry   <= (op == OP_SUB);
      shift_a <= a;
      shift_b <= (op == OP_SUB) ? ~b : b;
    end else if (step) begin
      cnt     <= cnt + CNT_W'(1);
      carry   <= cout;
      shift_a <= shift_a >> 1;
      shift_b <= shift_b >> 1;
      result  <= result_next;
      if (last_bit) begin
        // The carry register still holds the carry into the MSB on this bit.
        flag_v <= carry ^ cout;
        flag_c <= cout;
        flag_n <= sum_bit;
        flag_z <= (result_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb/tb_serial_addsub_ctrl.sv - self-checking bench for serial_addsub_ctrl at WIDTH 8 and 32
module tb_serial_addsub_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start8, op_8;
  logic [7:0]  a8, b8, res8;
  logic        ready8, busy8, done8, n8, z8, c8, v8;
  logic        start32, op_32;
  logic [31:0] a32, b32, res32;
  logic        ready32, busy32, done32, n32, z32, c32, v32;

  serial_addsub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op_8), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8), .result(res8),
    .flag_n(n8), .flag_z(z8), .flag_c(c8), .flag_v(v8)
  );

  serial_addsub_ctrl #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .op(op_32), .a(a32), .b(b32),
    .ready(ready32), .busy(busy32), .done(done32), .result(res32),
    .flag_n(n32), .flag_z(z32), .flag_c(c32), .flag_v(v32)
  );

  typedef struct {
    logic [63:0] res;
    logic        n, z, c, v;
    int          done_cyc;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   free8 = 0;
  int   free32 = 0;
  exp_t q8[$];
  exp_t q32[$];
  exp_t tmp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain modular arithmetic with textbook flag definitions.
  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic op);
    exp_t        e;
    logic [63:0] mask;
    logic [63:0] full;
    logic        sa, sb;
    mask = (64'd1 << w) - 64'd1;
    full = op ? (a - b) : (a + b);
    e.res = full & mask;
    e.n = e.res[w-1];
    e.z = (e.res == 64'd0);
    e.c = op ? (a >= b) : full[w];
    sa = a[w-1];
    sb = b[w-1];
    e.v = op ? ((sa != sb) && (e.n != sa)) : ((sa == sb) && (e.n != sa));
    e.done_cyc = 0;
    return e;
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      q8.delete();
      q32.delete();
      free8 = 0;
      free32 = 0;
    end else begin
      if (start8 && cyc >= free8) begin
        tmp = model(8, {56'd0, a8}, {56'd0, b8}, op_8);
        tmp.done_cyc = cyc + 8;
        q8.push_back(tmp);
        free8 = cyc + 9;
      end
      if (start32 && cyc >= free32) begin
        tmp = model(32, {32'd0, a32}, {32'd0, b32}, op_32);
        tmp.done_cyc = cyc + 32;
        q32.push_back(tmp);
        free32 = cyc + 33;
      end
    end
  end

  always @(negedge clk) begin
    logic ed, eb;
    if (cyc > 0) begin
      ed = (q8.size() > 0) && (q8[0].done_cyc == cyc);
      eb = (q8.size() > 0) && (cyc < q8[0].done_cyc);
      check("done8", done8, ed);
      check("busy8", busy8, eb);
      check("ready8", ready8, !eb);
      if (ed) begin
        check("result8", res8, q8[0].res);
        check("flags8_nzcv", {n8, z8, c8, v8}, {q8[0].n, q8[0].z, q8[0].c, q8[0].v});
        void'(q8.pop_front());
      end
      ed = (q32.size() > 0) && (q32[0].done_cyc == cyc);
      eb = (q32.size() > 0) && (cyc < q32[0].done_cyc);
      check("done32", done32, ed);
      check("busy32", busy32, eb);
      check("ready32", ready32, !eb);
      if (ed) begin
        check("result32", res32, q32[0].res);
        check("flags32_nzcv", {n32, z32, c32, v32}, {q32[0].n, q32[0].z, q32[0].c, q32[0].v});
        void'(q32.pop_front());
      end
    end
  end

  task automatic wait_done8(input string name);
    int n = 0;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done8) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic op);
    @(negedge clk);
    a8 = a; b8 = b; op_8 = op; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8("run8");
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic op);
    int n = 0;
    @(negedge clk);
    a32 = a; b32 = b; op_32 = op; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    while (!done32 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (!done32) begin
      checks++;
      failures++;
      $display("FAIL run32_timeout actual=no_done required=done");
    end
  endtask

  task automatic expect8(input string name, input logic [7:0] r, input logic [3:0] nzcv);
    check({name, "_result"}, res8, r);
    check({name, "_nzcv"}, {n8, z8, c8, v8}, nzcv);
  endtask

  initial begin
    exp_t m;
    int   gap;
    rst = 1'b1;
    start8 = 1'b0; op_8 = 1'b0; a8 = '0; b8 = '0;
    start32 = 1'b0; op_32 = 1'b0; a32 = '0; b32 = '0;

    m = model(8, 64'h3C, 64'h25, 1'b0);
    check("model_add", {m.res[7:0], m.n, m.z, m.c, m.v}, {8'h61, 4'b0000});
    m = model(8, 64'h80, 64'h01, 1'b1);
    check("model_sub_ovf", {m.res[7:0], m.n, m.z, m.c, m.v}, {8'h7F, 4'b0011});
    m = model(8, 64'hFF, 64'h01, 1'b0);
    check("model_add_carry", {m.res[7:0], m.n, m.z, m.c, m.v}, {8'h00, 4'b0110});
    m = model(8, 64'h7F, 64'h01, 1'b0);
    check("model_add_ovf", {m.res[7:0], m.n, m.z, m.c, m.v}, {8'h80, 4'b1001});

    // start while in reset must be ignored
    repeat (2) @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; start8 = 1'b1; start32 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; start32 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", ready8, 1'b1);
    check("reset_busy", busy8, 1'b0);
    check("reset_done", done8, 1'b0);
    check("reset_result", res8, 8'h00);
    check("reset_flags", {n8, z8, c8, v8}, 4'b0000);
    check("reset_result32", res32, 32'h0);

    run8(8'h3C, 8'h25, 1'b0); expect8("add", 8'h61, 4'b0000);
    run8(8'h80, 8'h01, 1'b1); expect8("sub_ovf", 8'h7F, 4'b0011);
    run8(8'h05, 8'h05, 1'b1); expect8("sub_zero", 8'h00, 4'b0110);
    run8(8'hFF, 8'h01, 1'b0); expect8("add_carry", 8'h00, 4'b0110);
    run8(8'h7F, 8'h01, 1'b0); expect8("add_ovf", 8'h80, 4'b1001);
    run8(8'h01, 8'h02, 1'b1); expect8("sub_borrow", 8'hFF, 4'b1000);

    // start pulsed mid-RUN with other operands is ignored
    @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; op_8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    a8 = 8'hF0; b8 = 8'h0F; op_8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8("ignore");
    expect8("ignore", 8'h33, 4'b0000);

    // start in the DONE cycle is taken back-to-back
    a8 = 8'h40; b8 = 8'h50; op_8 = 1'b0; start8 = 1'b1;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
      start8 = 1'b0;
    end while (!done8 && gap < 40);
    check("b2b_gap", gap, 9);
    expect8("b2b", 8'h90, 4'b1001);

    // reset at counter==4 aborts the operation
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'h0F; op_8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", ready8, 1'b1);
    check("abort_busy", busy8, 1'b0);
    check("abort_result", res8, 8'h00);
    check("abort_flags", {n8, z8, c8, v8}, 4'b0000);
    repeat (12) @(negedge clk);
    check("abort_no_done", done8, 1'b0);
    run8(8'h20, 8'h30, 1'b1); expect8("after_abort", 8'hF0, 4'b1000);

    run32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    check("w32_wrap", {res32, n32, z32, c32, v32}, {32'h0, 4'b0110});
    run32(32'h8000_0000, 32'h0000_0001, 1'b1);
    check("w32_sub_ovf", {res32, n32, z32, c32, v32}, {32'h7FFF_FFFF, 4'b0011});
    for (int i = 0; i < 16; i++) begin
      run32($urandom, $urandom, 1'(i % 2));
    end

    repeat (3) @(negedge clk);
    check("queue8_drained", q8.size(), 0);
    check("queue32_drained", q32.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
